// File: rtl/src_frame_sched.sv
// Round-robin frame scheduler sharing one ping-pong buffer write port between three sources.
// Optional stall-abort timeout is built when SRC_FRAME_SCHED_TIMEOUT_EN is defined.
module src_frame_sched #(
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_FRAME_LEN   = 256,
    parameter int C_GAP_CLK     = 4,
    parameter int C_TIMEOUT_CLK = 1024
) (
    input  logic                    I_clk,
    input  logic                    I_rst,
    input  logic [2:0]              I_srcEn,
    input  logic                    I_src0DataEn,
    input  logic                    I_src1DataEn,
    input  logic                    I_src2DataEn,
    input  logic [C_DATA_WIDTH-1:0] I_src0Data,
    input  logic [C_DATA_WIDTH-1:0] I_src1Data,
    input  logic [C_DATA_WIDTH-1:0] I_src2Data,
    output logic                    O_src0Ready,
    output logic                    O_src1Ready,
    output logic                    O_src2Ready,
    input  logic                    I_wReady,
    output logic                    O_wDataEn,
    output logic [C_DATA_WIDTH-1:0] O_wData,
    output logic                    O_frameStart,
    output logic                    O_frameEnd,
    output logic [1:0]              O_curSrc,
    output logic                    O_timeoutFlg
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, XFER = 2'd2, GAP = 2'd3} state_t;

    localparam logic [15:0] LAST_WORD = 16'(C_FRAME_LEN - 1);
    localparam logic [15:0] GAP_LAST  = 16'((C_GAP_CLK > 0) ? (C_GAP_CLK - 1) : 0);

    function automatic logic [1:0] nextIdx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : (idx + 2'd1);
    endfunction

    state_t                  state_r, stateNext_s;
    logic [1:0]              lastGrant_r, lastGrantNext_s;
    logic [1:0]              curSrc_r, curSrcNext_s;
    logic [15:0]             wordCnt_r, gapCnt_r;
    logic [1:0]              cand1_s, cand2_s, cand3_s, grantIdx_s;
    logic                    grantValid_s, selDataEn_s, accept_s, lastWord_s, timeout_s;
    logic [C_DATA_WIDTH-1:0] selData_s;
    logic                    wDataEn_r, frameStart_r, frameEnd_r, timeoutFlg_r;
    logic [C_DATA_WIDTH-1:0] wData_r;

    assign cand1_s = nextIdx(lastGrant_r);
    assign cand2_s = nextIdx(cand1_s);
    assign cand3_s = nextIdx(cand2_s);

    // Round-robin search starting just after the last granted source
    always_comb begin
        grantValid_s = 1'b1;
        grantIdx_s   = 2'd3;
        if (I_srcEn[cand1_s]) begin
            grantIdx_s = cand1_s;
        end else if (I_srcEn[cand2_s]) begin
            grantIdx_s = cand2_s;
        end else if (I_srcEn[cand3_s]) begin
            grantIdx_s = cand3_s;
        end else begin
            grantValid_s = 1'b0;
        end
    end

    // Granted-source word mux
    always_comb begin
        selDataEn_s = 1'b0;
        selData_s   = '0;
        case (curSrc_r)
            2'd0:    begin selDataEn_s = I_src0DataEn; selData_s = I_src0Data; end
            2'd1:    begin selDataEn_s = I_src1DataEn; selData_s = I_src1Data; end
            2'd2:    begin selDataEn_s = I_src2DataEn; selData_s = I_src2Data; end
            default: begin selDataEn_s = 1'b0;         selData_s = '0;         end
        endcase
    end

    assign O_src0Ready = (state_r == XFER) && (curSrc_r == 2'd0) && I_wReady;
    assign O_src1Ready = (state_r == XFER) && (curSrc_r == 2'd1) && I_wReady;
    assign O_src2Ready = (state_r == XFER) && (curSrc_r == 2'd2) && I_wReady;
    assign accept_s    = (state_r == XFER) && I_wReady && selDataEn_s;
    assign lastWord_s  = (wordCnt_r == LAST_WORD);

`ifdef SRC_FRAME_SCHED_TIMEOUT_EN
    logic [31:0] stallCnt_r;
    logic        stall_s;

    assign stall_s   = (state_r == XFER) && I_wReady && !selDataEn_s;
    assign timeout_s = stall_s && (stallCnt_r == 32'(C_TIMEOUT_CLK - 1));

    // Stall counter: ready downstream but the granted source is silent
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            stallCnt_r <= 32'd0;
        end else if ((state_r != XFER) || accept_s || timeout_s) begin
            stallCnt_r <= 32'd0;
        end else if (stall_s) begin
            stallCnt_r <= stallCnt_r + 32'd1;
        end else begin
            stallCnt_r <= stallCnt_r;
        end
    end
`else
    logic [31:0] unusedTimeout_s;
    assign unusedTimeout_s = 32'(C_TIMEOUT_CLK);
    assign timeout_s       = 1'b0;
`endif

    // Next-state, grant pointer and current-source selection
    always_comb begin
        stateNext_s     = state_r;
        lastGrantNext_s = lastGrant_r;
        curSrcNext_s    = curSrc_r;
        case (state_r)
            IDLE: begin
                if (I_srcEn != 3'b000) begin
                    stateNext_s = ARB;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            ARB: begin
                if (grantValid_s) begin
                    stateNext_s     = XFER;
                    curSrcNext_s    = grantIdx_s;
                    lastGrantNext_s = grantIdx_s;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            XFER: begin
                if ((accept_s && lastWord_s) || timeout_s) begin
                    curSrcNext_s = 2'd3;
                    if (C_GAP_CLK == 0) begin
                        stateNext_s = ARB;
                    end else begin
                        stateNext_s = GAP;
                    end
                end else begin
                    stateNext_s = XFER;
                end
            end
            GAP: begin
                if (gapCnt_r == GAP_LAST) begin
                    stateNext_s = ARB;
                end else begin
                    stateNext_s = GAP;
                end
            end
            default: begin
                stateNext_s  = IDLE;
                curSrcNext_s = 2'd3;
            end
        endcase
    end

    // FSM state, grant pointer and granted-source registers
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_r     <= IDLE;
            lastGrant_r <= 2'd2;
            curSrc_r    <= 2'd3;
        end else begin
            state_r     <= stateNext_s;
            lastGrant_r <= lastGrantNext_s;
            curSrc_r    <= curSrcNext_s;
        end
    end

    // Word counter within the frame and idle-gap counter
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            wordCnt_r <= 16'd0;
            gapCnt_r  <= 16'd0;
        end else begin
            if (accept_s) begin
                wordCnt_r <= lastWord_s ? 16'd0 : (wordCnt_r + 16'd1);
            end else if (timeout_s) begin
                wordCnt_r <= 16'd0;
            end else begin
                wordCnt_r <= wordCnt_r;
            end
            gapCnt_r <= (state_r == GAP) ? (gapCnt_r + 16'd1) : 16'd0;
        end
    end

    // Output stage: one cycle behind acceptance, data holds between words
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            wDataEn_r    <= 1'b0;
            wData_r      <= '0;
            frameStart_r <= 1'b0;
            frameEnd_r   <= 1'b0;
            timeoutFlg_r <= 1'b0;
        end else begin
            wDataEn_r    <= accept_s;
            wData_r      <= accept_s ? selData_s : wData_r;
            frameStart_r <= accept_s && (wordCnt_r == 16'd0);
            frameEnd_r   <= accept_s && lastWord_s;
            timeoutFlg_r <= timeout_s;
        end
    end

    assign O_wDataEn    = wDataEn_r;
    assign O_wData      = wData_r;
    assign O_frameStart = frameStart_r;
    assign O_frameEnd   = frameEnd_r;
    assign O_curSrc     = curSrc_r;
    assign O_timeoutFlg = timeoutFlg_r;
endmodule

// File: tb/tb_src_frame_sched.sv
// Directed bench for src_frame_sched (C_FRAME_LEN=4, C_GAP_CLK=2, C_TIMEOUT_CLK=8).
// The stall-timeout scenario runs only when SRC_FRAME_SCHED_TIMEOUT_EN is defined.
module tb_src_frame_sched;
    logic        sim_clk = 1'b0;
    logic        rst;
    logic [2:0]  srcEn;
    logic        src0En, src1En, src2En;
    logic [31:0] src0Data, src1Data, src2Data;
    logic        src0Ready, src1Ready, src2Ready;
    logic        wReady;
    logic        wDataEn, frameStart, frameEnd, timeoutFlg;
    logic [31:0] wData;
    logic [1:0]  curSrc;

    int          errCnt = 0;
    int          chkCnt = 0;
    int          cycle  = 0;
    logic [23:0] seq0, seq1, seq2;
    logic        wEnA [64];
    logic [31:0] dataA [64];
    logic        startA [64];
    logic        endA [64];
    logic        tflA [64];
    logic [1:0]  curA [64];
    logic        r0Seen, r1Seen, r2Seen;
    int          fsrc [4];
    int          cnt;

    always #5 sim_clk = ~sim_clk;

    src_frame_sched #(
        .C_DATA_WIDTH(32), .C_FRAME_LEN(4), .C_GAP_CLK(2), .C_TIMEOUT_CLK(8)
    ) dut (
        .I_clk(sim_clk), .I_rst(rst), .I_srcEn(srcEn),
        .I_src0DataEn(src0En), .I_src1DataEn(src1En), .I_src2DataEn(src2En),
        .I_src0Data(src0Data), .I_src1Data(src1Data), .I_src2Data(src2Data),
        .O_src0Ready(src0Ready), .O_src1Ready(src1Ready), .O_src2Ready(src2Ready),
        .I_wReady(wReady), .O_wDataEn(wDataEn), .O_wData(wData),
        .O_frameStart(frameStart), .O_frameEnd(frameEnd),
        .O_curSrc(curSrc), .O_timeoutFlg(timeoutFlg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sources advance their counter when their word is taken; outputs logged by cycle
    task automatic cyc();
        logic a0, a1, a2;
        #1;
        a0 = src0Ready & src0En;
        a1 = src1Ready & src1En;
        a2 = src2Ready & src2En;
        @(posedge sim_clk);
        #1;
        if (a0) seq0 = seq0 + 24'd1;
        if (a1) seq1 = seq1 + 24'd1;
        if (a2) seq2 = seq2 + 24'd1;
        src0Data = {8'h00, seq0};
        src1Data = {8'h01, seq1};
        src2Data = {8'h02, seq2};
        cycle++;
        if (cycle < 64) begin
            wEnA[cycle]   = wDataEn;
            dataA[cycle]  = wData;
            startA[cycle] = frameStart;
            endA[cycle]   = frameEnd;
            tflA[cycle]   = timeoutFlg;
            curA[cycle]   = curSrc;
        end
        r0Seen = r0Seen | src0Ready;
        r1Seen = r1Seen | src1Ready;
        r2Seen = r2Seen | src2Ready;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        repeat (2) @(posedge sim_clk);
        #1;
        seq0 = 24'd0; seq1 = 24'd0; seq2 = 24'd0;
        src0Data = 32'h0000_0000; src1Data = 32'h0100_0000; src2Data = 32'h0200_0000;
        for (int i = 0; i < 64; i++) begin
            wEnA[i] = 1'b0; dataA[i] = 32'd0; startA[i] = 1'b0;
            endA[i] = 1'b0; tflA[i] = 1'b0; curA[i] = 2'd0;
        end
        r0Seen = 1'b0; r1Seen = 1'b0; r2Seen = 1'b0;
        rst   = 1'b0;
        cycle = 0;
    endtask

    initial begin
        rst = 1'b1; srcEn = 3'b111; wReady = 1'b1;
        src0En = 1'b1; src1En = 1'b1; src2En = 1'b1;
        seq0 = 24'd0; seq1 = 24'd0; seq2 = 24'd0;
        src0Data = 32'h0000_0000; src1Data = 32'h0100_0000; src2Data = 32'h0200_0000;
        r0Seen = 1'b0; r1Seen = 1'b0; r2Seen = 1'b0;
        fsrc[0] = 0; fsrc[1] = 1; fsrc[2] = 2; fsrc[3] = 0;
        @(posedge sim_clk);
        #1;
        chk("rst_wDataEn", wDataEn, 32'd0);
        chk("rst_wData", wData, 32'd0);
        chk("rst_frameStart", frameStart, 32'd0);
        chk("rst_frameEnd", frameEnd, 32'd0);
        chk("rst_curSrc", curSrc, 32'd3);
        chk("rst_timeoutFlg", timeoutFlg, 32'd0);
        chk("rst_ready0", src0Ready, 32'd0);

        // All sources enabled: grants 0,1,2,0, 4 words per frame, 3 idle cycles between frames
        resetDut();
        repeat (28) cyc();
        for (int f = 0; f < 4; f++) begin
            chk("t1_curSrc", curA[2 + 7 * f], 32'(fsrc[f]));
            for (int i = 0; i < 4; i++) begin
                chk("t1_wDataEn", wEnA[3 + 7 * f + i], 32'd1);
                chk("t1_wData", dataA[3 + 7 * f + i],
                    {8'(fsrc[f]), 24'((f == 3) ? (4 + i) : i)});
                chk("t1_frameStart", startA[3 + 7 * f + i], (i == 0) ? 32'd1 : 32'd0);
                chk("t1_frameEnd", endA[3 + 7 * f + i], (i == 3) ? 32'd1 : 32'd0);
            end
        end
        for (int f = 0; f < 3; f++) begin
            for (int g = 7; g < 10; g++) chk("t1_gapIdle", wEnA[g + 7 * f], 32'd0);
        end
        chk("t1_curSrcAfterEnd", curA[6], 32'd3);
        cnt = 0;
        for (int c = 0; c < 29; c++) cnt += int'(tflA[c]);
        chk("t1_noTimeout", 32'(cnt), 32'd0);

        // Only source 1 enabled
        srcEn = 3'b010;
        resetDut();
        repeat (23) cyc();
        for (int f = 0; f < 3; f++) begin
            chk("t2_curSrc", curA[2 + 7 * f], 32'd1);
            for (int i = 0; i < 4; i++)
                chk("t2_wData", dataA[3 + 7 * f + i], {8'h01, 24'(4 * f + i)});
        end
        chk("t2_ready0Never", r0Seen, 32'd0);
        chk("t2_ready2Never", r2Seen, 32'd0);
        chk("t2_ready1Seen", r1Seen, 32'd1);

        // Backpressure: I_wReady low for 5 cycles after word 1
        srcEn = 3'b111;
        resetDut();
        repeat (4) cyc();
        wReady = 1'b0;
        repeat (5) cyc();
        wReady = 1'b1;
        repeat (7) cyc();
        chk("t3_w0", dataA[3], 32'h0000_0000);
        chk("t3_w1", dataA[4], 32'h0000_0001);
        for (int c = 5; c < 10; c++) chk("t3_stallIdle", wEnA[c], 32'd0);
        chk("t3_w2en", wEnA[10], 32'd1);
        chk("t3_w2", dataA[10], 32'h0000_0002);
        chk("t3_w3en", wEnA[11], 32'd1);
        chk("t3_w3", dataA[11], 32'h0000_0003);
        chk("t3_end", endA[11], 32'd1);
        chk("t3_endEarly", endA[10], 32'd0);
        chk("t3_accepted", 32'(seq0), 32'd4);
        chk("t3_next", dataA[15], 32'h0100_0000);
        chk("t3_nextStart", startA[15], 32'd1);

        // Clear enable of granted source 0 mid-frame
        resetDut();
        repeat (4) cyc();
        srcEn = 3'b110;
        repeat (7) cyc();
        for (int i = 0; i < 4; i++) begin
            chk("t4_wDataEn", wEnA[3 + i], 32'd1);
            chk("t4_wData", dataA[3 + i], 32'(i));
        end
        chk("t4_end", endA[6], 32'd1);
        chk("t4_nextGrant", curA[9], 32'd1);
        chk("t4_nextData", dataA[10], 32'h0100_0000);
        chk("t4_nextStart", startA[10], 32'd1);

        // Async reset at word 2
        srcEn = 3'b111;
        resetDut();
        repeat (5) cyc();
        chk("t5_word2", dataA[5], 32'h0000_0002);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_wDataEn", wDataEn, 32'd0);
        chk("t5_wData", wData, 32'd0);
        chk("t5_frameStart", frameStart, 32'd0);
        chk("t5_frameEnd", frameEnd, 32'd0);
        chk("t5_curSrc", curSrc, 32'd3);
        chk("t5_ready0", src0Ready, 32'd0);
        resetDut();
        repeat (4) cyc();
        chk("t5_firstGrant", curA[2], 32'd0);
        chk("t5_firstStart", startA[3], 32'd1);
        chk("t5_firstData", dataA[3], 32'h0000_0000);

`ifdef SRC_FRAME_SCHED_TIMEOUT_EN
        // Source 0 goes silent after word 1: abort 8 stall cycles later
        resetDut();
        repeat (4) cyc();
        src0En = 1'b0;
        repeat (12) cyc();
        src0En = 1'b1;
        chk("t6_timeoutPulse", tflA[12], 32'd1);
        cnt = 0;
        for (int c = 0; c < 17; c++) cnt += int'(tflA[c]);
        chk("t6_timeoutOnce", 32'(cnt), 32'd1);
        cnt = 0;
        for (int c = 0; c < 17; c++) cnt += int'(endA[c]);
        chk("t6_noFrameEnd", 32'(cnt), 32'd0);
        chk("t6_curSrcAbort", curA[12], 32'd3);
        chk("t6_nextGrant", curA[15], 32'd1);
        chk("t6_nextData", dataA[16], 32'h0100_0000);
`endif

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end
endmodule

// File: doc/src_frame_sched.md
Name: src_frame_sched

Overview:
- Round-robin frame scheduler that shares the single write port of the ping-pong buffer controller between three streaming sources: sequence data, single tone, and packed RF stub data.
- Grants one source at a time for a fixed-length frame, then inserts a programmable idle gap before re-arbitrating.
- Sits between the source generators and the ping-pong buffer `I_wDataEn`/`I_wData`/`I_wReady` interface.

Parameters:
- C_DATA_WIDTH, 32, width of source and output data.
- C_FRAME_LEN, 256, words per granted frame (legal range 1..65535).
- C_GAP_CLK, 4, idle cycles between frames (0 = no gap).
- C_TIMEOUT_CLK, 1024, stall limit; used only with the optional feature.

Ports:
- I_clk  in  1  system clock.
- I_rst  in  1  reset, asynchronous, active-high.
- I_srcEn  in  3  per-source enable mask, bit n = source n.
- I_src0DataEn / I_src1DataEn / I_src2DataEn  in  1  source word valid.
- I_src0Data / I_src1Data / I_src2Data  in  C_DATA_WIDTH  source word.
- O_src0Ready / O_src1Ready / O_src2Ready  out  1  source may present a word.
- I_wReady  in  1  downstream buffer ready.
- O_wDataEn  out  1  output word valid.
- O_wData  out  C_DATA_WIDTH  output word.
- O_frameStart  out  1  marks first word of frame.
- O_frameEnd  out  1  marks last word of frame.
- O_curSrc  out  2  granted source index, 3 = none.
- O_timeoutFlg  out  1  one-cycle stall-abort pulse.

Behaviour:
- Reset values: all outputs 0 except O_curSrc = 3. Word counter = 0. Last-grant pointer = 2, so source 0 wins the first arbitration. State = IDLE.
- FSM states: IDLE, ARB, XFER, GAP.
  - IDLE: goes to ARB when I_srcEn != 0.
  - ARB (1 cycle): search from last grant + 1, wrapping modulo 3. Grant the first enabled source, set O_curSrc, update the pointer, go to XFER. If none is enabled, go to IDLE.
  - XFER: O_srcNReady = I_wReady for the granted source only; the others stay 0. A word is accepted when granted ready & I_srcNDataEn.
  - Word count: the counter increments per accepted word. On acceptance of word C_FRAME_LEN-1, go to GAP, or to ARB if C_GAP_CLK = 0. O_curSrc returns to 3 when XFER exits.
  - GAP: count C_GAP_CLK cycles, then go to ARB.
- Output latency is 1 cycle from acceptance; the output registers load only on acceptance.
  - O_wDataEn is pulsed for each accepted word; O_wData holds its last value otherwise.
  - O_frameStart is set with word 0. O_frameEnd is set with word C_FRAME_LEN-1. With C_FRAME_LEN = 1, both are set on the same word.
- Backpressure:
  - I_wReady low: ready is low, the counter holds, and no word is emitted.
  - Ready is combinational from I_wReady, so at most one word arrives downstream in the cycle after I_wReady falls. The ping-pong buffer absorbs it.
- I_srcEn changes:
  - Clearing the enable bit of the granted source mid-frame does not truncate the frame; the grant is held to completion.
  - I_srcEn is sampled only in IDLE and ARB.
- Async reset mid-frame: the frame is dropped immediately, all state returns to reset values, and no O_frameEnd is emitted.
- Source words presented while not granted are ignored; no buffering.

Optional Feature:
- Macro: SRC_FRAME_SCHED_TIMEOUT_EN.
- With the macro: a stall counter runs in XFER.
  - Counts cycles where I_wReady = 1 and the granted I_srcNDataEn = 0; clears on any accepted word or on XFER exit.
  - On reaching C_TIMEOUT_CLK, O_timeoutFlg pulses 1 cycle, the frame is abandoned without O_frameEnd, the word counter clears, and the FSM goes to GAP, or to ARB if C_GAP_CLK = 0.
- Without the macro: O_timeoutFlg is tied 0, no stall counter is built, and a silent source holds the grant indefinitely.

Test Plan:
- Reset, all three sources enabled and always valid with incrementing data, I_wReady = 1, C_FRAME_LEN = 4, C_GAP_CLK = 2 -> grants in order 0,1,2,0. Each frame emits 4 contiguous O_wDataEn pulses with frameStart on word 0 and frameEnd on word 3, followed by a 2-cycle gap plus 1 ARB cycle.
- Only source 1 enabled -> O_curSrc = 1 every frame; sources 0 and 2 ready never asserted.
- I_wReady low for 5 cycles mid-frame -> counter holds and no words are lost or duplicated. At most one word is emitted after the fall. The frame still ends after exactly 4 accepted words.
- Clear I_srcEn[0] after word 1 of a source-0 frame -> frame completes with 4 words, and next grant = 1.
- Assert I_rst asynchronously at word 2 -> outputs zero immediately with O_curSrc = 3, and after release the first grant is source 0.
- With the macro enabled and C_TIMEOUT_CLK = 8, source 0 stops after word 1 -> O_timeoutFlg pulses exactly once 8 cycles later with no frameEnd, then source 1 is granted.
